ex_muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (operands and decoded mul/div op). It executes MULT, MULTU, DIV and DIVU over a fixed 33-cycle latency and holds the HI/LO architectural registers. It also services MTHI/MTLO writes and drives a busy signal that the hazard unit uses to stall MFHI/MFLO and any new mul/div op.

---
 rtl/ex_muldiv_unit.sv | 130 +++++++++++++
 tb/tb_ex_muldiv_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Fixed 33-cycle latency: 32 RUN iterations on magnitudes plus one FIX cycle for signs.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start/hi_we/lo_we are level requests sampled only while busy is low;
  // the requester holds them until busy drops, and anything seen while busy is dropped.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic [4:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mag_q;
  logic [WIDTH-1:0]   rs_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dz_q, done_q;

  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0] mul_acc, div_acc, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  always_comb begin
    rs_neg = ~op[0] & rs_val[WIDTH-1];
    rt_neg = ~op[0] & rt_val[WIDTH-1];
    rs_mag = rs_neg ? -rs_val : rs_val;
    rt_mag = rt_neg ? -rt_val : rt_val;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
    mul_acc = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: partial remainder in the high half, dividend bits feed in from below.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, mag_q};
    div_acc  = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    if (dz_q) begin
      res_hi = rs_q;
      res_lo = '1;
    end else if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_q     <= '0;
      rs_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            acc_q     <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
            mag_q     <= op[1] ? rt_mag : rs_mag;
            rs_q      <= rs_val;
            is_div_q  <= op[1];
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= op[1] & rs_neg;
            dz_q      <= op[1] & (rt_val == '0);
            cnt_q     <= '0;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= is_div_q ? div_acc : mul_acc;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: spec vector table, hand-written busy/reset sequences,
// and random operations scored against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] rs_val = '0, rt_val = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic [W-1:0] hi_o, lo_o;
  logic         busy, done;
  logic [1:0]   dbg_state;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {HI, LO} computed with wide integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; return p; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int pre);
    int cyc;
    int early;
    logic [63:0] e;
    cyc = pre;
    early = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (done) early++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(cyc), 64'd33);
    check({name, "_done_pulse"}, {63'd0, done}, 64'd1);
    check({name, "_done_while_busy"}, 64'(early), 64'd0);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: got no expected entry, required one", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_hi"}, {32'd0, hi_o}, {32'd0, e[63:32]});
      check({name, "_lo"}, {32'd0, lo_o}, {32'd0, e[31:0]});
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'd3, 32'd100,      32'd2,        32'h00000000, 32'h00000032};
    vecs[4] = '{2'd3, 32'h64,       32'd0,        32'h00000064, 32'hFFFFFFFF};
    vecs[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

    #1;
    check("reset_hi", {32'd0, hi_o}, 64'd0);
    check("reset_lo", {32'd0, lo_o}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Spec vectors issued back-to-back at the minimum interval.
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done($sformatf("vec%0d", i), 0);
      check($sformatf("vec%0d_tbl_hi", i), {32'd0, hi_o}, {32'd0, vecs[i].hi});
      check($sformatf("vec%0d_tbl_lo", i), {32'd0, lo_o}, {32'd0, vecs[i].lo});
    end
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);

    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", {32'd0, hi_o}, 64'h1234);
    check("mthi_lo_kept", {32'd0, lo_o}, 64'h80000000);
    lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", {32'd0, lo_o}, 64'h5678);

    // MTLO and a second start while busy must both be ignored.
    issue(2'd3, 32'd100, 32'd2);
    repeat (5) @(negedge clk);
    lo_we = 1'b1; wdata = 32'hDEAD; start = 1'b1; op = 2'd1; rs_val = 32'd3; rt_val = 32'd3;
    @(negedge clk);
    lo_we = 1'b0; start = 1'b0;
    check("busy_mtlo_lo", {32'd0, lo_o}, 64'h5678);
    check("busy_mtlo_hi", {32'd0, hi_o}, 64'h1234);
    wait_done("busy_ignore", 6);
    @(negedge clk);
    check("busy_no_requeue", {63'd0, busy}, 64'd0);

    // Start and MTLO together in IDLE: MT lands now, result overwrites later.
    lo_we = 1'b1; wdata = 32'hABCD;
    issue(2'd3, 32'd100, 32'd7);
    lo_we = 1'b0;
    check("start_mt_lo", {32'd0, lo_o}, 64'hABCD);
    wait_done("start_mt", 0);

    // Reset mid-operation discards the in-flight result.
    issue(2'd1, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_hi", {32'd0, hi_o}, 64'd0);
    check("midrst_lo", {32'd0, lo_o}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_state", {62'd0, dbg_state}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("postrst_no_done", 64'(pulses), 64'd0);
    check("postrst_lo", {32'd0, lo_o}, 64'd0);
    issue(2'd1, 32'd7, 32'd9);
    wait_done("after_reset", 0);
    check("after_reset_lo63", {32'd0, lo_o}, 64'd63);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(2'($urandom_range(0, 3)), pick(), pick());
      wait_done($sformatf("rnd%0d", i), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
